// File: rtl/camera_capture_pkg.sv
// Shared definitions for the camera capture path: active frame geometry,
// capture FSM encoding and saturating counter helpers. The frame buffer and
// VGA timing blocks import the same geometry.
package camera_capture_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;

  typedef enum logic [1:0] {
    SYNC_WAIT  = 2'd0,
    FRAME_IDLE = 2'd1,
    LINE       = 2'd2,
    SKIP       = 2'd3
  } cap_state_e;

  function automatic logic [9:0] sat_inc_col(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  function automatic logic [8:0] sat_inc_row(input logic [8:0] v);
    return (v == 9'h1FF) ? v : v + 9'd1;
  endfunction

endpackage

// File: rtl/camera_capture.sv
// OV7670 capture front end: registers the camera bus, pairs bytes into RGB565
// pixels and emits one write per pixel inside the active window.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// SYNC_WAIT  | between frames or after reset; waits for a VSYNC fall
// FRAME_IDLE | capturing frame, horizontal blanking (HREF low)
// LINE       | capturing frame, HREF high, bytes being paired
// SKIP       | frame rejected at its VSYNC fall; waits for VSYNC rise
//
// Pipeline: pins -> input regs -> pair stage -> output regs, so a low byte
// sampled at edge k produces a write strobe after edge k+2.
module camera_capture
  import camera_capture_pkg::*;
#(
  parameter int unsigned H_ACTIVE = camera_capture_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE = camera_capture_pkg::V_ACTIVE
) (
  input  logic        writeClk,
  input  logic        reset,
  input  logic [7:0]  camD,
  input  logic        camHref,
  input  logic        camVsync,
  input  logic        captureEn,
  output logic [9:0]  inX,
  output logic [8:0]  inY,
  output logic        writeEn,
  output logic [15:0] pixelIn,
  output logic        frameDone,
  output logic [7:0]  frameCount,
  output logic [8:0]  lineCount
);

  logic [7:0]  dD_q;
  logic        dHref_q;
  logic        dVsync_q;
  logic        vsync_dly_q;

  cap_state_e  state_q, state_d;

  logic        phase_q;
  logic [7:0]  hi_q;
  logic [9:0]  col_q;
  logic [8:0]  row_q;

  logic        pend_vld_q;
  logic [15:0] pend_pix_q;
  logic [9:0]  pend_x_q;
  logic [8:0]  pend_y_q;

  logic [9:0]  inX_q;
  logic [8:0]  inY_q;
  logic        writeEn_q;
  logic [15:0] pixelIn_q;
  logic        frameDone_q;
  logic [7:0]  frameCount_q;
  logic [8:0]  lineCount_q;

  logic        vsync_fall;
  logic        vsync_rise;
  logic        byte_en;
  logic        line_exit;
  logic        frame_end;
  logic        in_window;

  assign vsync_fall = vsync_dly_q & ~dVsync_q;
  assign vsync_rise = ~vsync_dly_q & dVsync_q;
  assign in_window  = (32'(col_q) < H_ACTIVE) && (32'(row_q) < V_ACTIVE);

  // Single register stage on the camera bus plus a delayed VSYNC for edge detect.
  always_ff @(posedge writeClk) begin
    if (reset) begin
      dD_q        <= 8'd0;
      dHref_q     <= 1'b0;
      dVsync_q    <= 1'b0;
      vsync_dly_q <= 1'b0;
    end else begin
      dD_q        <= camD;
      dHref_q     <= camHref;
      dVsync_q    <= camVsync;
      vsync_dly_q <= dVsync_q;
    end
  end

  // FSM state register.
  always_ff @(posedge writeClk) begin
    if (reset) state_q <= SYNC_WAIT;
    else       state_q <= state_d;
  end

  // Next state plus datapath strobes; captureEn only matters at the VSYNC fall.
  always_comb begin
    state_d   = state_q;
    byte_en   = 1'b0;
    line_exit = 1'b0;
    frame_end = 1'b0;
    case (state_q)
      SYNC_WAIT: begin
        if (vsync_fall) state_d = captureEn ? FRAME_IDLE : SKIP;
      end
      FRAME_IDLE: begin
        if (vsync_rise) begin
          state_d   = SYNC_WAIT;
          frame_end = 1'b1;
        end else if (dHref_q) begin
          state_d = LINE;
          byte_en = 1'b1;
        end
      end
      LINE: begin
        if (vsync_rise) begin
          state_d   = SYNC_WAIT;
          frame_end = 1'b1;
        end else if (dHref_q) begin
          byte_en = 1'b1;
        end else begin
          state_d   = FRAME_IDLE;
          line_exit = 1'b1;
        end
      end
      SKIP: begin
        if (vsync_rise) state_d = SYNC_WAIT;
      end
      default: state_d = SYNC_WAIT;
    endcase
  end

  // Byte pairing, column/row position and the pair stage feeding the outputs.
  always_ff @(posedge writeClk) begin
    if (reset) begin
      phase_q    <= 1'b0;
      hi_q       <= 8'd0;
      col_q      <= 10'd0;
      row_q      <= 9'd0;
      pend_vld_q <= 1'b0;
      pend_pix_q <= 16'd0;
      pend_x_q   <= 10'd0;
      pend_y_q   <= 9'd0;
    end else begin
      pend_vld_q <= byte_en & phase_q & in_window;
      if (byte_en && phase_q) begin
        pend_pix_q <= {hi_q, dD_q};
        pend_x_q   <= col_q;
        pend_y_q   <= row_q;
      end
      if (vsync_fall) begin
        col_q   <= 10'd0;
        row_q   <= 9'd0;
        phase_q <= 1'b0;
      end else if (line_exit) begin
        // an unpaired high byte is simply forgotten here
        col_q   <= 10'd0;
        phase_q <= 1'b0;
        row_q   <= sat_inc_row(row_q);
      end else if (byte_en) begin
        phase_q <= ~phase_q;
        if (!phase_q) hi_q  <= dD_q;
        else          col_q <= sat_inc_col(col_q);
      end
    end
  end

  // Frame-buffer write port; position and pixel hold between strobes.
  always_ff @(posedge writeClk) begin
    if (reset) begin
      writeEn_q <= 1'b0;
      inX_q     <= 10'd0;
      inY_q     <= 9'd0;
      pixelIn_q <= 16'd0;
    end else begin
      writeEn_q <= pend_vld_q;
      if (pend_vld_q) begin
        inX_q     <= pend_x_q;
        inY_q     <= pend_y_q;
        pixelIn_q <= pend_pix_q;
      end
    end
  end

  // End-of-frame pulse and frame statistics.
  always_ff @(posedge writeClk) begin
    if (reset) begin
      frameDone_q  <= 1'b0;
      frameCount_q <= 8'd0;
      lineCount_q  <= 9'd0;
    end else begin
      frameDone_q <= frame_end;
      if (frame_end) begin
        frameCount_q <= frameCount_q + 8'd1;
        lineCount_q  <= row_q;
      end
    end
  end

  assign inX        = inX_q;
  assign inY        = inY_q;
  assign writeEn    = writeEn_q;
  assign pixelIn    = pixelIn_q;
  assign frameDone  = frameDone_q;
  assign frameCount = frameCount_q;
  assign lineCount  = lineCount_q;

endmodule

// File: tb/tb_camera_capture.sv
// Bench for camera_capture with a reduced 4x3 active window.
module tb_camera_capture;

  localparam int unsigned H = 4;
  localparam int unsigned V = 3;

  logic        writeClk = 1'b0;
  logic        reset;
  logic [7:0]  camD;
  logic        camHref;
  logic        camVsync;
  logic        captureEn;
  logic [9:0]  inX;
  logic [8:0]  inY;
  logic        writeEn;
  logic [15:0] pixelIn;
  logic        frameDone;
  logic [7:0]  frameCount;
  logic [8:0]  lineCount;

  always #5 writeClk = ~writeClk;

  camera_capture #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .writeClk   (writeClk),
    .reset      (reset),
    .camD       (camD),
    .camHref    (camHref),
    .camVsync   (camVsync),
    .captureEn  (captureEn),
    .inX        (inX),
    .inY        (inY),
    .writeEn    (writeEn),
    .pixelIn    (pixelIn),
    .frameDone  (frameDone),
    .frameCount (frameCount),
    .lineCount  (lineCount)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0]  d;
    logic        href;
    logic        vsync;
    logic        we;
    logic [15:0] pix;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        fd;
    logic [7:0]  fc;
    logic [8:0]  lc;
  } vec_t;

  typedef struct {
    logic [15:0] pix;
    logic [9:0]  x;
    logic [8:0]  y;
  } wr_t;

  typedef logic [7:0] bytes_t[$];

  vec_t   vt[13];
  wr_t    got[$];
  wr_t    exp_q[$];
  int     fd_seen = 0;
  bytes_t ln;

  // write/frameDone monitor, sampled just after each rising edge
  always @(posedge writeClk) begin
    #1;
    if (writeEn === 1'b1) got.push_back('{pixelIn, inX, inY});
    if (frameDone === 1'b1) fd_seen++;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int d, input int h, input int v, input int we,
                              input int pix, input int x, input int y,
                              input int fd, input int fc, input int lc);
    vec_t r;
    r.d = 8'(d); r.href = 1'(h); r.vsync = 1'(v); r.we = 1'(we);
    r.pix = 16'(pix); r.x = 10'(x); r.y = 9'(y); r.fd = 1'(fd);
    r.fc = 8'(fc); r.lc = 9'(lc);
    return r;
  endfunction

  task automatic cyc(input logic [7:0] d, input logic h, input logic v);
    @(negedge writeClk);
    camD = d; camHref = h; camVsync = v;
  endtask

  task automatic frame_start();
    repeat (2) cyc(8'h00, 1'b0, 1'b1);
    repeat (3) cyc(8'h00, 1'b0, 1'b0);
  endtask

  task automatic frame_end();
    repeat (4) cyc(8'h00, 1'b0, 1'b1);
  endtask

  task automatic send_line(input bytes_t b);
    foreach (b[i]) cyc(b[i], 1'b1, 1'b0);
    repeat (3) cyc(8'h00, 1'b0, 1'b0);
  endtask

  task automatic add_px(inout bytes_t b, input logic [15:0] p);
    b.push_back(p[15:8]);
    b.push_back(p[7:0]);
  endtask

  task automatic clear_mon();
    got.delete();
    exp_q.delete();
    fd_seen = 0;
  endtask

  task automatic check_writes(input string tag);
    int n;
    check($sformatf("%s_wr_count", tag), 32'(got.size()), 32'(exp_q.size()));
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_pix%0d", tag, i), 32'(got[i].pix), 32'(exp_q[i].pix));
      check($sformatf("%s_x%0d", tag, i), 32'(got[i].x), 32'(exp_q[i].x));
      check($sformatf("%s_y%0d", tag, i), 32'(got[i].y), 32'(exp_q[i].y));
    end
  endtask

  task automatic check_frame(input string tag, input int fd, input int fc, input int lc);
    check($sformatf("%s_frameDone_pulses", tag), 32'(fd_seen), 32'(fd));
    check($sformatf("%s_frameCount", tag), 32'(frameCount), 32'(fc));
    check($sformatf("%s_lineCount", tag), 32'(lineCount), 32'(lc));
  endtask

  task automatic check_zero_outputs(input string tag);
    check($sformatf("%s_writeEn", tag), 32'(writeEn), 32'd0);
    check($sformatf("%s_inX", tag), 32'(inX), 32'd0);
    check($sformatf("%s_inY", tag), 32'(inY), 32'd0);
    check($sformatf("%s_pixelIn", tag), 32'(pixelIn), 32'd0);
    check($sformatf("%s_frameDone", tag), 32'(frameDone), 32'd0);
    check($sformatf("%s_frameCount", tag), 32'(frameCount), 32'd0);
    check($sformatf("%s_lineCount", tag), 32'(lineCount), 32'd0);
  endtask

  initial begin
    // per-cycle table: one short captured frame with a 0xCD,0xAB latency probe.
    // record n holds inputs driven before edge n and outputs expected after it.
    //          d     h  v  we pix      x  y  fd fc lc
    vt[0]  = mk(8'h00, 0, 1, 0, 16'h0000, 0, 0, 0, 0, 0);
    vt[1]  = mk(8'h00, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0);
    vt[2]  = mk(8'h00, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0);
    vt[3]  = mk(8'hCD, 1, 0, 0, 16'h0000, 0, 0, 0, 0, 0);
    vt[4]  = mk(8'hAB, 1, 0, 0, 16'h0000, 0, 0, 0, 0, 0);
    vt[5]  = mk(8'h12, 1, 0, 0, 16'h0000, 0, 0, 0, 0, 0);
    vt[6]  = mk(8'h34, 1, 0, 1, 16'hCDAB, 0, 0, 0, 0, 0);
    vt[7]  = mk(8'h00, 0, 0, 0, 16'hCDAB, 0, 0, 0, 0, 0);
    vt[8]  = mk(8'h00, 0, 0, 1, 16'h1234, 1, 0, 0, 0, 0);
    vt[9]  = mk(8'h00, 0, 0, 0, 16'h1234, 1, 0, 0, 0, 0);
    vt[10] = mk(8'h00, 0, 1, 0, 16'h1234, 1, 0, 0, 0, 0);
    vt[11] = mk(8'h00, 0, 1, 0, 16'h1234, 1, 0, 1, 1, 1);
    vt[12] = mk(8'h00, 0, 1, 0, 16'h1234, 1, 0, 0, 1, 1);

    reset = 1'b1; camD = 8'h00; camHref = 1'b0; camVsync = 1'b0; captureEn = 1'b1;
    repeat (3) @(negedge writeClk);
    check_zero_outputs("reset");
    reset = 1'b0;

    foreach (vt[i]) begin
      cyc(vt[i].d, vt[i].href, vt[i].vsync);
      @(posedge writeClk);
      #1;
      check($sformatf("tbl%0d_writeEn", i), 32'(writeEn), 32'(vt[i].we));
      check($sformatf("tbl%0d_pixelIn", i), 32'(pixelIn), 32'(vt[i].pix));
      check($sformatf("tbl%0d_inX", i), 32'(inX), 32'(vt[i].x));
      check($sformatf("tbl%0d_inY", i), 32'(inY), 32'(vt[i].y));
      check($sformatf("tbl%0d_frameDone", i), 32'(frameDone), 32'(vt[i].fd));
      check($sformatf("tbl%0d_frameCount", i), 32'(frameCount), 32'(vt[i].fc));
      check($sformatf("tbl%0d_lineCount", i), 32'(lineCount), 32'(vt[i].lc));
    end

    // full frame of 0xF800 pixels
    clear_mon();
    frame_start();
    for (int y = 0; y < int'(V); y++) begin
      ln.delete();
      for (int x = 0; x < int'(H); x++) begin
        add_px(ln, 16'hF800);
        exp_q.push_back('{16'hF800, 10'(x), 9'(y)});
      end
      send_line(ln);
    end
    frame_end();
    check_writes("full");
    check_frame("full", 1, 2, 3);

    // over-long first line and a row past the active window
    clear_mon();
    frame_start();
    ln.delete();
    for (int x = 0; x < int'(H) + 2; x++) begin
      add_px(ln, 16'h0100 + 16'(x));
      if (x < int'(H)) exp_q.push_back('{16'h0100 + 16'(x), 10'(x), 9'd0});
    end
    send_line(ln);
    for (int y = 1; y <= int'(V); y++) begin
      ln.delete();
      add_px(ln, 16'hA000 + 16'(y));
      if (y < int'(V)) exp_q.push_back('{16'hA000 + 16'(y), 10'd0, 9'(y)});
      send_line(ln);
    end
    frame_end();
    check_writes("clip");
    check_frame("clip", 1, 3, 4);

    // odd byte count: trailing high byte dropped, next line starts clean
    clear_mon();
    frame_start();
    ln = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    send_line(ln);
    ln = '{8'hA1, 8'hB2};
    send_line(ln);
    frame_end();
    exp_q.push_back('{16'h1234, 10'd0, 9'd0});
    exp_q.push_back('{16'h5678, 10'd1, 9'd0});
    exp_q.push_back('{16'hA1B2, 10'd0, 9'd1});
    check_writes("odd");
    check_frame("odd", 1, 4, 2);

    // HREF between frames, then a frame skipped by captureEn=0 at its VSYNC fall
    clear_mon();
    for (int i = 0; i < 4; i++) cyc(8'h50 + 8'(i), 1'b1, 1'b1);
    captureEn = 1'b0;
    frame_start();
    ln = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_line(ln);
    captureEn = 1'b1;
    send_line(ln);
    frame_end();
    check_writes("skip");
    check_frame("skip", 0, 4, 2);

    clear_mon();
    frame_start();
    ln.delete();
    add_px(ln, 16'hC0DE);
    add_px(ln, 16'hBEEF);
    send_line(ln);
    frame_end();
    exp_q.push_back('{16'hC0DE, 10'd0, 9'd0});
    exp_q.push_back('{16'hBEEF, 10'd1, 9'd0});
    check_writes("resume");
    check_frame("resume", 1, 5, 1);

    // reset in the middle of a line with a pixel still in flight
    clear_mon();
    frame_start();
    ln.delete();
    add_px(ln, 16'h7777);
    send_line(ln);
    cyc(8'h55, 1'b1, 1'b0);
    cyc(8'h66, 1'b1, 1'b0);
    cyc(8'h77, 1'b1, 1'b0);
    @(negedge writeClk);
    reset = 1'b1; camD = 8'h88;
    @(posedge writeClk);
    #1;
    check_zero_outputs("midrst");
    @(negedge writeClk);
    reset = 1'b0;
    clear_mon();
    ln = '{8'h99, 8'h98, 8'h97, 8'h96};
    send_line(ln);
    send_line(ln);
    frame_end();
    check_writes("postrst");
    check($sformatf("postrst_frameDone_pulses"), 32'(fd_seen), 32'd0);

    clear_mon();
    frame_start();
    ln.delete();
    add_px(ln, 16'h4242);
    send_line(ln);
    frame_end();
    exp_q.push_back('{16'h4242, 10'd0, 9'd0});
    check_writes("restart");
    check_frame("restart", 1, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
